vcd_change_decoder: RTL and testbench
=====================================

Name: vcd_change_decoder

Overview:
- Consumer end of the value-change dump stream produced by our dump-control logic.
- Accepts serialized dump records: time marks, value changes, dumpall checkpoint brackets, dumpoff and dumpon.
- Maintains a shadow copy of every dumped signal's current value and validity.
- Forwards timestamped change events downstream through a 1-deep registered output stage, and flags protocol violations.

Parameters:
- NUM_SIGS, 16: number of dumped signals; ids 0..NUM_SIGS-1.
- ID_W, 4: signal id width; must satisfy 2**ID_W >= NUM_SIGS.
- VAL_W, 8: signal value width.
- TIME_W, 32: simulation-time width.

Ports:
- clock  in  1  single clock; all state updates on posedge.
- reset_n  in  1  asynchronous active-low reset.
- rec_valid  in  1  input record valid.
- rec_ready  out  1  input record accepted when rec_valid && rec_ready.
- rec_type  in  3  record type: 0 NOP, 1 TIME, 2 CHANGE, 3 CKPT_BEGIN, 4 CKPT_END, 5 DUMPOFF, 6 DUMPON, 7 reserved.
- rec_id  in  ID_W  signal id (CHANGE only).
- rec_data  in  TIME_W  absolute time (TIME); value in bits [VAL_W-1:0] (CHANGE).
- evt_valid  out  1  change event valid.
- evt_ready  in  1  downstream accepts event.
- evt_id  out  ID_W  changed signal id.
- evt_value  out  VAL_W  new value.
- evt_time  out  TIME_W  time of change.
- rd_id  in  ID_W  shadow read address.
- rd_value  out  VAL_W  shadow value, registered, 1-cycle latency.
- rd_known  out  1  shadow entry valid, registered with rd_value.
- cur_time  out  TIME_W  last accepted TIME value.
- state  out  2  0 INIT, 1 ACTIVE, 2 PAUSED, 3 CKPT.
- ckpt_count  out  16  completed checkpoints; saturates at 16'hFFFF.
- err  out  1  sticky protocol error.
- err_code  out  3  first error cause; later errors do not overwrite.

Behaviour:
- Reset (async, reset_n=0) clears everything:
  - state=INIT; all shadow values 0; all known bits 0.
  - cur_time=0, ckpt_count=0, err=0, err_code=0.
  - evt_valid=0, rd_value=0, rd_known=0.
  - rec_ready=1 once reset is released.
- Reset mid-record or mid-checkpoint discards all partial state.
- rec_ready = !evt_valid || evt_ready. Accepted CHANGE records load the event register in the same cycle, so a full-rate stream drains without bubbles.
- TIME:
  - rec_data >= cur_time: cur_time <= rec_data.
  - rec_data < cur_time: err_code 1; cur_time unchanged.
  - Legal in all states.
- CHANGE:
  - rec_id >= NUM_SIGS: err_code 2; record dropped.
  - State INIT or PAUSED: err_code 3; record dropped.
  - State ACTIVE: update shadow value, set known, emit event.
  - State CKPT: update shadow value, set known, set that id's seen bit, emit event.
  - Every emitted event carries evt_time = cur_time.
  - Emitted even if the value is unchanged; the dump is authoritative.
- CKPT_BEGIN:
  - From INIT/ACTIVE: go to CKPT and clear the seen vector.
  - From PAUSED or CKPT: err_code 4; state unchanged.
- CKPT_END:
  - From CKPT with all NUM_SIGS seen bits set: go to ACTIVE; ckpt_count++.
  - From CKPT with any seen bit missing: err_code 5; go to ACTIVE; ckpt_count unchanged.
  - From any other state: err_code 4.
- DUMPOFF:
  - From ACTIVE: go to PAUSED; clear all known bits; shadow values retained.
  - From PAUSED: no-op.
  - From INIT/CKPT: err_code 4.
- DUMPON:
  - From PAUSED: go to INIT; a checkpoint is required before changes are accepted again.
  - From ACTIVE: no-op; the first dumpon has no effect.
  - From INIT/CKPT: no-op.
- NOP and reserved type 7: accepted, no effect. Type 7 sets err_code 6.
- err is sticky and does not block processing.
- Read port:
  - rd_value/rd_known reflect the shadow as of the previous clock edge.
  - A same-cycle write and read to the same id returns the old value; the new value appears the next cycle.
- evt_valid/evt_* hold stable while evt_valid && !evt_ready.

Test Plan:
- Reset, then CKPT_BEGIN, CHANGE ids 0..15 with value=id, CKPT_END -> state=ACTIVE, ckpt_count=1, rd_id=5 returns 5/known=1 next cycle, 16 events emitted with evt_time=0.
- TIME 100, CHANGE id 3 val 8'hA5 with evt_ready=0 for 4 cycles -> evt held with id 3, value A5, time 100; rec_ready=0 throughout; one event total after evt_ready rises.
- From ACTIVE: DUMPOFF, CHANGE id 1 -> err=1, err_code=3, rd_known(1)=0. Then DUMPON -> state=INIT.
- CKPT_BEGIN, CHANGE ids 0..14 only, CKPT_END -> err_code=5, state=ACTIVE, ckpt_count unchanged.
- TIME 500 then TIME 400 -> err_code=1, cur_time=500. A later CHANGE id 20 (NUM_SIGS=16, ID_W=5) leaves err_code=1.
- Assert reset_n low during CKPT after 7 changes -> immediate INIT, all outputs 0, ckpt_count=0. A fresh full checkpoint then succeeds.

Source files
------------

// File: rtl/vcd_change_decoder.sv
// Value-change dump consumer: keeps a shadow of every dumped signal, forwards
// timestamped change events through a 1-deep output register and flags protocol errors.
module vcd_change_decoder #(
    parameter int NUM_SIGS = 16,
    parameter int ID_W     = 4,
    parameter int VAL_W    = 8,
    parameter int TIME_W   = 32
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              rec_valid,
    output logic              rec_ready,
    input  logic [2:0]        rec_type,
    input  logic [ID_W-1:0]   rec_id,
    input  logic [TIME_W-1:0] rec_data,
    output logic              evt_valid,
    input  logic              evt_ready,
    output logic [ID_W-1:0]   evt_id,
    output logic [VAL_W-1:0]  evt_value,
    output logic [TIME_W-1:0] evt_time,
    input  logic [ID_W-1:0]   rd_id,
    output logic [VAL_W-1:0]  rd_value,
    output logic              rd_known,
    output logic [TIME_W-1:0] cur_time,
    output logic [1:0]        state,
    output logic [15:0]       ckpt_count,
    output logic              err,
    output logic [2:0]        err_code
);

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_PAUSED = 2'd2,
        ST_CKPT   = 2'd3
    } state_e;

    typedef enum logic [2:0] {
        REC_NOP        = 3'd0,
        REC_TIME       = 3'd1,
        REC_CHANGE     = 3'd2,
        REC_CKPT_BEGIN = 3'd3,
        REC_CKPT_END   = 3'd4,
        REC_DUMPOFF    = 3'd5,
        REC_DUMPON     = 3'd6,
        REC_RSVD       = 3'd7
    } rec_type_e;

    typedef enum logic [2:0] {
        ERR_NONE       = 3'd0,
        ERR_TIME_BACK  = 3'd1,
        ERR_BAD_ID     = 3'd2,
        ERR_NOT_LIVE   = 3'd3,
        ERR_BAD_SEQ    = 3'd4,
        ERR_CKPT_SHORT = 3'd5,
        ERR_RSVD       = 3'd6
    } err_e;

    localparam logic [ID_W:0] ID_LIMIT = (ID_W + 1)'(NUM_SIGS);

    state_e              state_q;
    state_e              state_d;
    logic [VAL_W-1:0]    shadow_val [NUM_SIGS];
    logic [NUM_SIGS-1:0] known_q;
    logic [NUM_SIGS-1:0] seen_q;

    logic                rec_fire;
    logic                id_ok;
    logic                do_write;
    logic                time_load;
    logic                clear_known;
    logic                clear_seen;
    logic                ckpt_inc;
    err_e                err_cause;
    logic [VAL_W-1:0]    rd_sel_value;
    logic                rd_sel_known;

    // A CHANGE may be accepted whenever the event slot is empty or draining this cycle.
    assign rec_ready = !evt_valid || evt_ready;
    assign rec_fire  = rec_valid && rec_ready;
    assign id_ok     = {1'b0, rec_id} < ID_LIMIT;
    assign state     = state_q;

    // NOTE: every output of this block gets a default first, so no path leaves one unassigned and infers a latch.
    always_comb begin
        state_d     = state_q;
        do_write    = 1'b0;
        time_load   = 1'b0;
        clear_known = 1'b0;
        clear_seen  = 1'b0;
        ckpt_inc    = 1'b0;
        err_cause   = ERR_NONE;
        if (rec_fire) begin
            case (rec_type)
                REC_TIME: begin
                    if (rec_data >= cur_time) time_load = 1'b1;
                    else                      err_cause = ERR_TIME_BACK;
                end
                REC_CHANGE: begin
                    if (!id_ok)                                              err_cause = ERR_BAD_ID;
                    else if (state_q == ST_INIT || state_q == ST_PAUSED)     err_cause = ERR_NOT_LIVE;
                    else                                                     do_write  = 1'b1;
                end
                REC_CKPT_BEGIN: begin
                    if (state_q == ST_INIT || state_q == ST_ACTIVE) begin
                        state_d    = ST_CKPT;
                        clear_seen = 1'b1;
                    end else begin
                        err_cause = ERR_BAD_SEQ;
                    end
                end
                REC_CKPT_END: begin
                    if (state_q == ST_CKPT) begin
                        state_d = ST_ACTIVE;
                        if (&seen_q) ckpt_inc  = 1'b1;
                        else         err_cause = ERR_CKPT_SHORT;
                    end else begin
                        err_cause = ERR_BAD_SEQ;
                    end
                end
                REC_DUMPOFF: begin
                    if (state_q == ST_ACTIVE) begin
                        state_d     = ST_PAUSED;
                        clear_known = 1'b1;
                    end else if (state_q != ST_PAUSED) begin
                        err_cause = ERR_BAD_SEQ;
                    end
                end
                REC_DUMPON: begin
                    // Leaving pause demands a fresh checkpoint before changes are trusted.
                    if (state_q == ST_PAUSED) state_d = ST_INIT;
                end
                REC_RSVD: err_cause = ERR_RSVD;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_INIT;
            cur_time   <= '0;
            ckpt_count <= '0;
            err        <= 1'b0;
            err_code   <= '0;
        end else begin
            state_q <= state_d;
            if (time_load) cur_time <= rec_data;
            if (ckpt_inc && ckpt_count != 16'hFFFF) ckpt_count <= ckpt_count + 16'd1;
            if (err_cause != ERR_NONE && !err) begin
                err      <= 1'b1;
                err_code <= err_cause;
            end
        end
    end

    // NOTE: the shadow array sits in the reset branch because reset must return every stored value to 0.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_SIGS; i++) shadow_val[i] <= '0;
            known_q <= '0;
            seen_q  <= '0;
        end else begin
            if (clear_known) known_q <= '0;
            if (clear_seen)  seen_q  <= '0;
            for (int i = 0; i < NUM_SIGS; i++) begin
                if (do_write && rec_id == ID_W'(i)) begin
                    shadow_val[i] <= rec_data[VAL_W-1:0];
                    known_q[i]    <= 1'b1;
                    if (state_q == ST_CKPT) seen_q[i] <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            evt_valid <= 1'b0;
            evt_id    <= '0;
            evt_value <= '0;
            evt_time  <= '0;
        end else if (do_write) begin
            evt_valid <= 1'b1;
            evt_id    <= rec_id;
            evt_value <= rec_data[VAL_W-1:0];
            evt_time  <= cur_time;
        end else if (evt_ready) begin
            evt_valid <= 1'b0;
        end
    end

    always_comb begin
        rd_sel_value = '0;
        rd_sel_known = 1'b0;
        for (int i = 0; i < NUM_SIGS; i++) begin
            if (rd_id == ID_W'(i)) begin
                rd_sel_value = shadow_val[i];
                rd_sel_known = known_q[i];
            end
        end
    end

    // NOTE: non-blocking updates mean a same-edge write is not yet visible here, so the read returns the old value.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_value <= '0;
            rd_known <= 1'b0;
        end else begin
            rd_value <= rd_sel_value;
            rd_known <= rd_sel_known;
        end
    end

endmodule

// File: tb/tb_vcd_change_decoder.sv
// Self-checking bench for vcd_change_decoder: directed protocol scenarios followed by
// a randomized record stream, all checked against a behavioural reference model.
module tb_vcd_change_decoder;

    localparam int NUM_SIGS = 16;
    localparam int ID_W     = 5;
    localparam int VAL_W    = 8;
    localparam int TIME_W   = 32;

    localparam logic [2:0] T_NOP   = 3'd0;
    localparam logic [2:0] T_TIME  = 3'd1;
    localparam logic [2:0] T_CHG   = 3'd2;
    localparam logic [2:0] T_CKB   = 3'd3;
    localparam logic [2:0] T_CKE   = 3'd4;
    localparam logic [2:0] T_OFF   = 3'd5;
    localparam logic [2:0] T_ON    = 3'd6;
    localparam logic [2:0] T_RSVD  = 3'd7;

    typedef struct {
        logic [ID_W-1:0]   id;
        logic [VAL_W-1:0]  value;
        logic [TIME_W-1:0] tm;
    } evt_t;

    logic              clock;
    logic              reset_n;
    logic              rec_valid;
    logic              rec_ready;
    logic [2:0]        rec_type;
    logic [ID_W-1:0]   rec_id;
    logic [TIME_W-1:0] rec_data;
    logic              evt_valid;
    logic              evt_ready;
    logic [ID_W-1:0]   evt_id;
    logic [VAL_W-1:0]  evt_value;
    logic [TIME_W-1:0] evt_time;
    logic [ID_W-1:0]   rd_id;
    logic [VAL_W-1:0]  rd_value;
    logic              rd_known;
    logic [TIME_W-1:0] cur_time;
    logic [1:0]        state;
    logic [15:0]       ckpt_count;
    logic              err;
    logic [2:0]        err_code;

    vcd_change_decoder #(
        .NUM_SIGS(NUM_SIGS), .ID_W(ID_W), .VAL_W(VAL_W), .TIME_W(TIME_W)
    ) dut (
        .clock(clock), .reset_n(reset_n),
        .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_type(rec_type),
        .rec_id(rec_id), .rec_data(rec_data),
        .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_id(evt_id),
        .evt_value(evt_value), .evt_time(evt_time),
        .rd_id(rd_id), .rd_value(rd_value), .rd_known(rd_known),
        .cur_time(cur_time), .state(state), .ckpt_count(ckpt_count),
        .err(err), .err_code(err_code)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int n_evt    = 0;
    int ready_mode = 0;   // 0 always ready, 1 random, 2 stalled
    evt_t exp_q[$];

    // Reference model: state numbers follow the published state encoding.
    int                m_state;
    logic [TIME_W-1:0] m_time;
    int                m_ckpt;
    bit                m_err;
    int                m_err_code;
    logic [VAL_W-1:0]  m_val   [NUM_SIGS];
    bit                m_known [NUM_SIGS];
    bit                m_seen  [NUM_SIGS];

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_time = '0; m_ckpt = 0; m_err = 0; m_err_code = 0;
        for (int i = 0; i < NUM_SIGS; i++) begin
            m_val[i] = '0; m_known[i] = 0; m_seen[i] = 0;
        end
        exp_q.delete();
    endtask

    task automatic model_error(input int code);
        if (!m_err) begin
            m_err = 1; m_err_code = code;
        end
    endtask

    task automatic model_apply(input logic [2:0] t, input logic [ID_W-1:0] id, input logic [TIME_W-1:0] d);
        int  idx;
        bit  all_seen;
        evt_t e;
        idx = int'(id);
        case (t)
            T_TIME: if (d >= m_time) m_time = d; else model_error(1);
            T_CHG: begin
                if (idx >= NUM_SIGS) model_error(2);
                else if (m_state == 0 || m_state == 2) model_error(3);
                else begin
                    m_val[idx] = d[VAL_W-1:0];
                    m_known[idx] = 1;
                    if (m_state == 3) m_seen[idx] = 1;
                    e.id = id; e.value = d[VAL_W-1:0]; e.tm = m_time;
                    exp_q.push_back(e);
                end
            end
            T_CKB: begin
                if (m_state == 0 || m_state == 1) begin
                    m_state = 3;
                    for (int i = 0; i < NUM_SIGS; i++) m_seen[i] = 0;
                end else model_error(4);
            end
            T_CKE: begin
                if (m_state == 3) begin
                    all_seen = 1;
                    for (int i = 0; i < NUM_SIGS; i++) if (!m_seen[i]) all_seen = 0;
                    if (all_seen) begin
                        if (m_ckpt < 65535) m_ckpt++;
                    end else model_error(5);
                    m_state = 1;
                end else model_error(4);
            end
            T_OFF: begin
                if (m_state == 1) begin
                    m_state = 2;
                    for (int i = 0; i < NUM_SIGS; i++) m_known[i] = 0;
                end else if (m_state != 2) model_error(4);
            end
            T_ON:   if (m_state == 2) m_state = 0;
            T_RSVD: model_error(6);
            default: ;
        endcase
    endtask

    task automatic step();
        @(posedge clock); #1;
    endtask

    // Called and returns at posedge+1; the record is applied to the model at the accepting edge.
    task automatic send_rec(input logic [2:0] t, input logic [ID_W-1:0] id, input logic [TIME_W-1:0] d);
        int  waited;
        bit  done;
        waited = 0; done = 0;
        rec_valid = 1'b1; rec_type = t; rec_id = id; rec_data = d;
        while (!done) begin
            @(negedge clock);
            if (rec_ready) begin
                @(posedge clock);
                model_apply(t, id, d);
                #1;
                done = 1;
            end else begin
                waited++;
                if (waited > 200) begin
                    check("rec_accept_timeout", 1'b0, 1'b1);
                    done = 1;
                end
                @(posedge clock); #1;
            end
        end
        rec_valid = 1'b0;
    endtask

    task automatic ckpt_run(input int n_ids, input logic [VAL_W-1:0] mask);
        send_rec(T_CKB, '0, '0);
        for (int i = 0; i < n_ids; i++) send_rec(T_CHG, ID_W'(i), TIME_W'(i) ^ TIME_W'(mask));
        send_rec(T_CKE, '0, '0);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            step();
            n++;
        end
        check("event_drain", exp_q.size(), 0);
    endtask

    task automatic check_status(input string tag);
        @(negedge clock);
        check({tag, "_state"}, state, m_state);
        check({tag, "_cur_time"}, cur_time, m_time);
        check({tag, "_ckpt_count"}, ckpt_count, m_ckpt);
        check({tag, "_err"}, err, m_err);
        check({tag, "_err_code"}, err_code, m_err_code);
        step();
    endtask

    task automatic check_read(input int id);
        rd_id = ID_W'(id);
        step();
        @(negedge clock);
        check("rd_value", rd_value, m_val[id]);
        check("rd_known", rd_known, m_known[id]);
        step();
    endtask

    task automatic do_reset();
        rec_valid = 1'b0;
        reset_n = 1'b0;
        model_reset();
        step();
        reset_n = 1'b1;
        step();
    endtask

    initial begin
        evt_ready = 1'b1;
        forever begin
            @(posedge clock); #2;
            case (ready_mode)
                0:       evt_ready = 1'b1;
                1:       evt_ready = ($urandom_range(0, 9) < 7);
                default: evt_ready = 1'b0;
            endcase
        end
    end

    // Event monitor: the 1-deep output must always hold exactly the oldest expected event.
    initial begin
        forever begin
            @(negedge clock);
            if (reset_n) begin
                check("evt_occupancy", evt_valid, exp_q.size() != 0);
                if (evt_valid && exp_q.size() != 0) begin
                    check("evt_id", evt_id, exp_q[0].id);
                    check("evt_value", evt_value, exp_q[0].value);
                    check("evt_time", evt_time, exp_q[0].tm);
                    if (evt_ready) begin
                        void'(exp_q.pop_front());
                        n_evt++;
                    end
                end
            end
        end
    end

    initial begin
        int               n0;
        int               r;
        logic [VAL_W-1:0] old_v;
        bit               old_k;
        logic [VAL_W-1:0] new_v;
        logic [TIME_W-1:0] t_next;

        reset_n = 1'b0; rec_valid = 1'b0; rec_type = '0; rec_id = '0; rec_data = '0; rd_id = '0;
        model_reset();
        repeat (3) @(posedge clock);
        #1 reset_n = 1'b1;

        // Reset state
        @(negedge clock);
        check("reset_rec_ready", rec_ready, 1'b1);
        check("reset_evt_valid", evt_valid, 1'b0);
        check("reset_rd_value", rd_value, 0);
        check("reset_rd_known", rd_known, 1'b0);
        step();
        check_status("reset");

        // Full checkpoint with value = id
        n0 = n_evt;
        ckpt_run(NUM_SIGS, 8'h00);
        wait_drain();
        check("ckpt1_events", n_evt - n0, 16);
        check_status("ckpt1");
        @(negedge clock);
        check("ckpt1_state_active", state, 1);
        check("ckpt1_count", ckpt_count, 1);
        step();
        check_read(5);
        @(negedge clock);
        check("ckpt1_rd5_value", rd_value, 5);
        check("ckpt1_rd5_known", rd_known, 1'b1);
        step();

        // Backpressure: event held while downstream stalls
        send_rec(T_TIME, '0, 32'd100);
        wait_drain();
        ready_mode = 2;
        step();
        send_rec(T_CHG, 5'd3, 32'h0000_00A5);
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            check("hold_evt_valid", evt_valid, 1'b1);
            check("hold_evt_id", evt_id, 3);
            check("hold_evt_value", evt_value, 8'hA5);
            check("hold_evt_time", evt_time, 100);
            check("hold_rec_ready", rec_ready, 1'b0);
            step();
        end
        n0 = n_evt;
        ready_mode = 0;
        wait_drain();
        check("hold_event_count", n_evt - n0, 1);

        // Pause, rejected change, resume into INIT
        send_rec(T_OFF, '0, '0);
        send_rec(T_CHG, 5'd1, 32'h77);
        check_status("paused");
        @(negedge clock);
        check("paused_err", err, 1'b1);
        check("paused_err_code", err_code, 3);
        step();
        check_read(1);
        send_rec(T_ON, '0, '0);
        @(negedge clock);
        check("dumpon_state_init", state, 0);
        step();

        // Incomplete checkpoint
        do_reset();
        ckpt_run(NUM_SIGS - 1, 8'h00);
        wait_drain();
        check_status("short_ckpt");
        @(negedge clock);
        check("short_ckpt_err_code", err_code, 5);
        check("short_ckpt_state", state, 1);
        check("short_ckpt_count", ckpt_count, 0);
        step();

        // Time going backwards, then a later bad id keeps the first cause
        do_reset();
        send_rec(T_TIME, '0, 32'd500);
        send_rec(T_TIME, '0, 32'd400);
        @(negedge clock);
        check("time_back_err_code", err_code, 1);
        check("time_back_cur_time", cur_time, 500);
        step();
        send_rec(T_CHG, 5'd20, 32'h12);
        check_status("bad_id");
        @(negedge clock);
        check("bad_id_err_code_sticky", err_code, 1);
        step();

        // Reset asserted in the middle of a checkpoint
        do_reset();
        ckpt_run(NUM_SIGS, 8'h3C);
        wait_drain();
        check_status("pre_midreset");
        send_rec(T_CKB, '0, '0);
        for (int i = 0; i < 7; i++) send_rec(T_CHG, ID_W'(i), 32'h55 + 32'(i));
        #2 reset_n = 1'b0;
        model_reset();
        #1;
        check("midreset_state", state, 0);
        check("midreset_evt_valid", evt_valid, 1'b0);
        check("midreset_ckpt_count", ckpt_count, 0);
        check("midreset_cur_time", cur_time, 0);
        check("midreset_err", err, 1'b0);
        check("midreset_rd_value", rd_value, 0);
        check("midreset_rd_known", rd_known, 1'b0);
        @(posedge clock); #1;
        reset_n = 1'b1;
        step();
        ckpt_run(NUM_SIGS, 8'h5A);
        wait_drain();
        check_status("post_midreset");
        @(negedge clock);
        check("post_midreset_count", ckpt_count, 1);
        step();
        check_read(9);

        // Same-cycle write and read of one id
        rd_id = 5'd7;
        old_v = m_val[7];
        old_k = m_known[7];
        new_v = old_v ^ 8'hFF;
        send_rec(T_CHG, 5'd7, TIME_W'(new_v));
        @(negedge clock);
        check("rd_same_cycle_value", rd_value, old_v);
        check("rd_same_cycle_known", rd_known, old_k);
        step();
        @(negedge clock);
        check("rd_next_cycle_value", rd_value, new_v);
        check("rd_next_cycle_known", rd_known, 1'b1);
        step();
        wait_drain();

        // Randomized record stream with random downstream backpressure
        do_reset();
        ready_mode = 1;
        ckpt_run(NUM_SIGS, 8'hC3);
        for (int k = 0; k < 300; k++) begin
            r = $urandom_range(0, 99);
            if (r < 55) begin
                send_rec(T_CHG, ID_W'($urandom_range(0, 19)), TIME_W'($urandom_range(0, 255)));
            end else if (r < 70) begin
                if ($urandom_range(0, 7) == 0 && m_time > 20)
                    t_next = m_time - TIME_W'($urandom_range(1, 20));
                else
                    t_next = m_time + TIME_W'($urandom_range(0, 50));
                send_rec(T_TIME, '0, t_next);
            end else if (r < 75) send_rec(T_OFF, '0, '0);
            else if (r < 80)     send_rec(T_ON, '0, '0);
            else if (r < 86)     send_rec(T_CKB, '0, '0);
            else if (r < 92)     send_rec(T_CKE, '0, '0);
            else if (r < 97)     send_rec(T_NOP, ID_W'($urandom_range(0, 31)), TIME_W'($urandom));
            else                 send_rec(T_RSVD, '0, '0);
            if (k % 25 == 24) begin
                check_status("rand");
                check_read($urandom_range(0, NUM_SIGS - 1));
            end
        end
        ready_mode = 0;
        wait_drain();
        check_status("final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
